// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared encodings for the JK LED bank sequencer.
// FSM states, mode selects and per-bit JK command codes.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_VERIFY = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_CHASE = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  // {j,k} per bit
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Minimal command moving one flop from cur to nxt.
  function automatic logic [1:0] jk_for(
    input logic cur,
    input logic nxt
  );
    logic [1:0] c;
    if (cur == nxt)
      c = JK_HOLD;
    else if (nxt)
      c = JK_SET;
    else
      c = JK_RESET;
    return c;
  endfunction

endpackage

// File: rtl/jk_bank_sequencer_prescaler.sv
// jk_prescaler: PW-bit step-rate counter, sync clear, tick at DIV-1.
// Ports: clk, rst (async high), clr, en in; tick out (comb, en-qualified).
module jk_prescaler #(
  parameter int DIV = 25_000_000,
  parameter int PW  = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PW-1:0] TC = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == TC);

endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: drives J/K/step for an N-bit JK LED bank at a
// prescaled rate and checks each update against the expected Q.
// Ports: clk, rst (async high), start, stop, mode[1:0], q[N-1:0] in;
//        j, k [N-1:0], step, busy, err out.
// Option: JK_SEQ_STEP_EN adds step_req for single manual steps from IDLE.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 25_000_000,
  parameter int PW  = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
`ifdef JK_SEQ_STEP_EN
  input  logic         step_req,
`endif
  input  logic [N-1:0] q,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic         step,
  output logic         busy,
  output logic         err
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [N-1:0] exp_q, exp_d;
  logic         err_q, err_d;
  logic         single_q, single_d;

  logic         tick;
  logic         presc_clr;
  logic         presc_en;
  logic         run_fire;
  logic         req_fire;
  logic         fire;
  logic [1:0]   sel_mode;
  logic [N-1:0] nx;
  logic [N-1:0] jg;
  logic [N-1:0] kg;

  // Counts only in RUN; stop zeroes it so a restart begins a full period.
  assign presc_en  = (state_q == ST_RUN);
  assign presc_clr = (state_q != ST_RUN) || stop;

  jk_prescaler #(
    .DIV (DIV),
    .PW  (PW)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  assign run_fire = (state_q == ST_RUN) && tick && !stop;

`ifdef JK_SEQ_STEP_EN
  assign req_fire = (state_q == ST_IDLE) && step_req
                    && !start && !stop;
`else
  assign req_fire = 1'b0;
`endif

  assign fire = run_fire || req_fire;

  // A manual step fires from IDLE before mode is latched.
  assign sel_mode = (state_q == ST_IDLE) ? mode : mode_q;

  always_comb begin
    nx = '0;
    unique case (sel_mode)
      MODE_COUNT: nx = q + ONE;
      MODE_CHASE: nx = $onehot(q)
                       ? {q[N-2:0], q[N-1]} : ONE;
      MODE_BLINK: nx = ~q;
      MODE_CLEAR: nx = '0;
    endcase
  end

  always_comb begin
    jg = '0;
    kg = '0;
    for (int i = 0; i < N; i++) begin
      case (sel_mode)
        MODE_BLINK: {jg[i], kg[i]} = JK_TOGGLE;
        MODE_CLEAR: {jg[i], kg[i]} = JK_RESET;
        default:    {jg[i], kg[i]} = jk_for(q[i], nx[i]);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COUNT;
      exp_q    <= '0;
      err_q    <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      single_q <= single_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    exp_d    = exp_q;
    err_d    = err_q;
    single_d = single_q;
    unique case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d  = ST_RUN;
          mode_d   = mode;
          err_d    = 1'b0;
          single_d = 1'b0;
        end else if (req_fire) begin
          state_d  = ST_VERIFY;
          mode_d   = mode;
          err_d    = 1'b0;
          single_d = 1'b1;
          exp_d    = nx;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (run_fire) begin
          state_d = ST_VERIFY;
          exp_d   = nx;
        end
      end
      ST_VERIFY: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (q != exp_q) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
        end else if (single_q || mode_q == MODE_CLEAR) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (stop)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    step = fire;
    j    = fire ? jg : '0;
    k    = fire ? kg : '0;
    busy = (state_q == ST_RUN) || (state_q == ST_VERIFY);
    err  = err_q;
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: JK bank model on j/k/step, cycle model of the
// sequencer compared every cycle, plus literal Q/flag expectations.
module tb_jk_bank_sequencer;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int PW  = 8;
  localparam int MSK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic [1:0]   mode;
  logic [N-1:0] q;
  logic [N-1:0] j;
  logic [N-1:0] k;
  logic         step;
  logic         busy;
  logic         err;
  logic         stuck;
`ifdef JK_SEQ_STEP_EN
  logic         step_req;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jk_bank_sequencer #(
    .N   (N),
    .DIV (DIV),
    .PW  (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
`ifdef JK_SEQ_STEP_EN
    .step_req (step_req),
`endif
    .q        (q),
    .j        (j),
    .k        (k),
    .step     (step),
    .busy     (busy),
    .err      (err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h",
               nm, $time, got, want);
    end
  endtask

  // JK LED bank; optional stuck-at-0 on bit 0.
  always @(posedge clk) begin
    logic [N-1:0] nq;
    if (step === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        case ({j[i], k[i]})
          2'b10:   nq[i] = 1'b1;
          2'b01:   nq[i] = 1'b0;
          2'b11:   nq[i] = ~q[i];
          default: nq[i] = q[i];
        endcase
      end
      if (stuck)
        nq[0] = 1'b0;
      q <= nq;
    end
  end

  function automatic int f_next(input int md, input int qv);
    int ones;
    ones = 0;
    case (md)
      0: return (qv + 1) & MSK;
      1: begin
        for (int b = 0; b < N; b++)
          ones += (qv >> b) & 1;
        if (ones == 1)
          return ((qv << 1) | (qv >> (N - 1))) & MSK;
        return 1;
      end
      2: return (~qv) & MSK;
      default: return 0;
    endcase
  endfunction

  function automatic int f_j(input int md, input int qv);
    case (md)
      2: return MSK;
      3: return 0;
      default: return f_next(md, qv) & ~qv & MSK;
    endcase
  endfunction

  function automatic int f_k(input int md, input int qv);
    case (md)
      2, 3: return MSK;
      default: return ~f_next(md, qv) & qv & MSK;
    endcase
  endfunction

  // Sequencer model: time since start decides step/verify cycles.
  int m_busy   = 0;
  int m_fault  = 0;
  int m_err    = 0;
  int m_mode   = 0;
  int m_t      = 0;
  int m_pred   = 0;
  int m_single = 0;

  always @(negedge clk) begin
    int e_step;
    int md;
    int ph;
    int qi;
    qi = int'(q);
    if (rst === 1'b1) begin
      chk("rst_step", step, 0);
      chk("rst_j", j, 0);
      chk("rst_k", k, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      m_busy = 0; m_fault = 0; m_err = 0;
      m_mode = 0; m_t = 0; m_single = 0;
    end else begin
      md = m_mode;
      e_step = 0;
      ph = m_t % (DIV + 1);
      if (m_busy != 0 && !stop && ph == DIV - 1)
        e_step = 1;
`ifdef JK_SEQ_STEP_EN
      if (m_busy == 0 && m_fault == 0 && step_req
          && !start && !stop) begin
        e_step = 1;
        md = int'(mode);
      end
`endif
      chk("step", step, e_step);
      chk("j", j, e_step != 0 ? f_j(md, qi) : 0);
      chk("k", k, e_step != 0 ? f_k(md, qi) : 0);
      chk("busy", busy, m_busy);
      chk("err", err, m_err);
      if (stop) begin
        m_busy = 0;
        m_fault = 0;
      end else if (m_busy == 0 && m_fault == 0) begin
        if (start) begin
          m_busy = 1; m_mode = int'(mode);
          m_err = 0; m_t = 0; m_single = 0;
        end
`ifdef JK_SEQ_STEP_EN
        else if (step_req) begin
          m_busy = 1; m_mode = int'(mode);
          m_err = 0; m_t = DIV; m_single = 1;
          m_pred = f_next(m_mode, qi);
        end
`endif
      end else if (m_busy != 0) begin
        if (ph == DIV - 1)
          m_pred = f_next(m_mode, qi);
        if (ph == DIV) begin
          if (qi != m_pred) begin
            m_err = 1; m_fault = 1; m_busy = 0;
          end else if (m_single != 0 || m_mode == 3) begin
            m_busy = 0;
          end
        end
        m_t++;
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [1:0] m);
    tick_n(1);
    mode  = m;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
  endtask

  task automatic halt();
    tick_n(1);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
  endtask

  // Returns just after the edge on which the bank took the step.
  task automatic wait_step(input string nm);
    int seen;
    seen = 0;
    for (int c = 0; c < 3 * (DIV + 1) && seen == 0; c++) begin
      @(negedge clk);
      if (step === 1'b1)
        seen = 1;
    end
    chk({nm, "_seen"}, seen, 1);
    tick_n(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'b00;
    q     = '0;
    stuck = 1'b0;
`ifdef JK_SEQ_STEP_EN
    step_req = 1'b0;
`endif
    tick_n(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);

    // reset while running
    q = 4'b0000;
    go(2'b00);
    tick_n(7);
    chk("rst_run_q", q, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_busy", busy, 0);
    chk("rst_run_step", step, 0);
    tick_n(1);
    rst = 1'b0;

    // count-up through wrap
    q = 4'b0000;
    go(2'b00);
    for (int i = 1; i <= 16; i++) begin
      wait_step("count");
      chk("count_q", q, i % 16);
    end
    chk("count_err", err, 0);
    halt();

    // chase
    q = 4'b0100;
    go(2'b01);
    wait_step("chase");
    chk("chase_q1", q, 4'b1000);
    wait_step("chase");
    chk("chase_q2", q, 4'b0001);
    halt();
    q = 4'b0110;
    go(2'b01);
    wait_step("chase_bad");
    chk("chase_not_onehot", q, 4'b0001);
    halt();

    // blink
    q = 4'b1010;
    go(2'b10);
    wait_step("blink");
    chk("blink_q1", q, 4'b0101);
    wait_step("blink");
    chk("blink_q2", q, 4'b1010);
    wait_step("blink");
    chk("blink_q3", q, 4'b0101);
    halt();

    // clear
    q = 4'b1011;
    go(2'b11);
    wait_step("clear");
    chk("clear_q", q, 4'b0000);
    tick_n(1);
    @(negedge clk);
    chk("clear_idle", busy, 0);

    // stuck bit -> fault
    tick_n(1);
    q = 4'b0000;
    stuck = 1'b1;
    go(2'b00);
    wait_step("stuck");
    chk("stuck_q", q, 4'b0000);
    tick_n(1);
    @(negedge clk);
    chk("fault_err", err, 1);
    chk("fault_busy", busy, 0);
    go(2'b00);
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (step === 1'b1)
        cnt++;
    end
    chk("fault_no_steps", cnt, 0);
    chk("fault_start_ign", busy, 0);
    halt();
    @(negedge clk);
    chk("stop_keeps_err", err, 1);
    stuck = 1'b0;
    tick_n(1);
    go(2'b00);
    @(negedge clk);
    chk("start_clr_err", err, 0);
    chk("start_busy", busy, 1);
    halt();

    // start and stop together in IDLE
    tick_n(1);
    start = 1'b1;
    stop  = 1'b1;
    tick_n(1);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    chk("start_stop_idle", busy, 0);

    // stop on the terminal-count cycle
    tick_n(1);
    q = 4'b0101;
    go(2'b00);
    tick_n(3);
    stop = 1'b1;
    @(negedge clk);
    chk("stop_tc_step", step, 0);
    tick_n(1);
    stop = 1'b0;
    @(negedge clk);
    chk("stop_tc_idle", busy, 0);
    chk("stop_tc_q", q, 4'b0101);

`ifdef JK_SEQ_STEP_EN
    tick_n(1);
    q = 4'b0011;
    mode = 2'b00;
    step_req = 1'b1;
    @(negedge clk);
    chk("req_step", step, 1);
    tick_n(1);
    step_req = 1'b0;
    chk("req_q", q, 4'b0100);
    tick_n(1);
    @(negedge clk);
    chk("req_idle", busy, 0);
`endif

    tick_n(3);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
